// File: rtl/alu_control_unit.sv
// alu_control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit ALU datapath.
// Owns the program counter, instruction register and compare flag; outputs decode from state and IR.
module alu_control_unit #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic [7:0]  pc,
    output logic [3:0]  alu_opcode,
    output logic        alu_src,
    output logic        alu_b_sel,
    input  logic        alu_compare,
    output logic [1:0]  rf_addr_a,
    output logic [1:0]  rf_addr_b,
    output logic        rf_we,
    output logic [1:0]  rf_waddr,
    output logic        rf_wsel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_CMP   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_BEQ   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        flag_q, flag_d;

    logic [3:0]  ir_op_s;
    logic [1:0]  ir_rd_s;
    logic [1:0]  ir_rs_s;
    logic [7:0]  ir_imm_s;
    logic [1:0]  addr_a_s;
    logic [1:0]  addr_b_s;

    // Register-writing arithmetic/logic ops (ADD..XOR)
    function automatic logic op_is_alu(input logic [3:0] op);
        return (op <= OP_XOR);
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Ops that need the ALU evaluating in EXECUTE (ALU ops, CMP, address generation)
    function automatic logic op_uses_alu(input logic [3:0] op);
        return (op <= OP_STORE);
    endfunction

    assign ir_op_s  = ir_q[15:12];
    assign ir_rd_s  = ir_q[11:10];
    assign ir_rs_s  = ir_q[9:8];
    assign ir_imm_s = ir_q[7:0];
    assign pc       = pc_q;

    // Memory ops read the base from rs on port A; STORE reads its data from rd on port B
    assign addr_a_s = op_is_mem(ir_op_s) ? ir_rs_s : ir_rd_s;
    assign addr_b_s = (ir_op_s == OP_STORE) ? ir_rd_s : ir_rs_s;

    // State, program counter, instruction register and compare flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RESET;
            ir_q    <= 16'h0000;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flag_q  <= flag_d;
        end
    end

    // Next-state and architectural register updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flag_d  = flag_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_data;
                    pc_d    = pc_q + 8'd1;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_d = (ir_op_s == OP_HALT) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (ir_op_s)
                    OP_CMP: begin
                        flag_d  = alu_compare;
                        state_d = ST_FETCH;
                    end
                    OP_LOAD, OP_STORE: begin
                        state_d = ST_MEM;
                    end
                    OP_BEQ: begin
                        // pc_q already points past the branch, so the offset is relative to the next instruction
                        pc_d    = flag_q ? (pc_q + ir_imm_s) : pc_q;
                        state_d = ST_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = ir_imm_s;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        state_d = op_is_alu(ir_op_s) ? ST_WB : ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = (ir_op_s == OP_LOAD) ? ST_WB : ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath control decoded from state and IR; everything idles at 0 outside its phase
    always_comb begin
        instr_req  = 1'b0;
        alu_opcode = 4'h0;
        alu_src    = 1'b0;
        alu_b_sel  = 1'b0;
        rf_addr_a  = 2'b00;
        rf_addr_b  = 2'b00;
        rf_we      = 1'b0;
        rf_waddr   = 2'b00;
        rf_wsel    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_req = 1'b0;
            end
            ST_FETCH: begin
                instr_req = 1'b1;
            end
            ST_DECODE: begin
                rf_addr_a = addr_a_s;
                rf_addr_b = addr_b_s;
            end
            ST_EXECUTE: begin
                rf_addr_a  = addr_a_s;
                rf_addr_b  = addr_b_s;
                alu_opcode = ir_op_s;
                alu_src    = op_uses_alu(ir_op_s);
                alu_b_sel  = op_is_mem(ir_op_s);
            end
            ST_MEM: begin
                rf_addr_a  = addr_a_s;
                rf_addr_b  = addr_b_s;
                alu_opcode = ir_op_s;
                alu_src    = 1'b1;
                alu_b_sel  = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = (ir_op_s == OP_STORE);
            end
            ST_WB: begin
                rf_addr_a  = addr_a_s;
                rf_addr_b  = addr_b_s;
                rf_we      = 1'b1;
                rf_waddr   = ir_rd_s;
                rf_wsel    = (ir_op_s == OP_LOAD);
                alu_src    = op_is_alu(ir_op_s);
                alu_opcode = op_is_alu(ir_op_s) ? ir_op_s : 4'h0;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Testbench for alu_control_unit: per-instruction expected cycle schedules built from the
// instruction semantics, replayed against the DUT with random noise on ignored inputs.
module tb_alu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [7:0]  pc;
    logic [3:0]  alu_opcode;
    logic        alu_src;
    logic        alu_b_sel;
    logic        alu_compare;
    logic [1:0]  rf_addr_a;
    logic [1:0]  rf_addr_b;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic        rf_wsel;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        halted;

    alu_control_unit #(.PC_RESET(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_valid(instr_valid), .instr_data(instr_data),
        .pc(pc), .alu_opcode(alu_opcode), .alu_src(alu_src), .alu_b_sel(alu_b_sel),
        .alu_compare(alu_compare), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic [7:0] pc;
        logic [3:0] op;
        logic       src;
        logic       bsel;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       we;
        logic [1:0] wa;
        logic       wsel;
        logic       dreq;
        logic       dwe;
        logic       halt;
    } ov_t;

    typedef struct packed {
        logic        iv;
        logic [15:0] id;
        logic        cmp;
        logic        rdy;
        ov_t         exp;
    } cyc_t;

    cyc_t       sched[$];
    ov_t        act[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_cyc   = 0;
    logic [7:0] m_pc;
    logic       m_flag;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    function automatic ov_t dut_vec();
        ov_t v;
        v.req  = instr_req;  v.pc   = pc;        v.op   = alu_opcode;
        v.src  = alu_src;    v.bsel = alu_b_sel; v.ra   = rf_addr_a;
        v.rb   = rf_addr_b;  v.we   = rf_we;     v.wa   = rf_waddr;
        v.wsel = rf_wsel;    v.dreq = dmem_req;  v.dwe  = dmem_we;
        v.halt = halted;
        return v;
    endfunction

    task automatic check(input string name, input ov_t a, input ov_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic push(input logic iv, input logic [15:0] id, input logic cmp,
                        input logic rdy, input ov_t exp);
        cyc_t c;
        c.iv = iv; c.id = id; c.cmp = cmp; c.rdy = rdy; c.exp = exp;
        sched.push_back(c);
    endtask

    // Expected cycles of one instruction: fd fetch stalls, md memory stalls, cmpv = ALU compare result
    task automatic add_instr(input logic [15:0] ins, input int fd, input int md, input logic cmpv);
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic       mem_op;
        ov_t        v;
        op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
        mem_op = (op == 4'd6) || (op == 4'd7);
        for (int i = 0; i < fd; i++) begin
            v = '0; v.req = 1'b1; v.pc = m_pc;
            push(1'b0, rnd16(), rbit(), rbit(), v);
        end
        v = '0; v.req = 1'b1; v.pc = m_pc;
        push(1'b1, ins, rbit(), rbit(), v);
        m_pc = m_pc + 8'd1;
        v = '0; v.pc = m_pc;
        v.ra = mem_op ? rs : rd;
        v.rb = (op == 4'd7) ? rd : rs;
        push(rbit(), rnd16(), rbit(), rbit(), v);
        if (op == 4'hF) return;
        v.op = op; v.src = (op <= 4'd7); v.bsel = mem_op;
        push(rbit(), rnd16(), cmpv, rbit(), v);
        if (op == 4'd5) m_flag = cmpv;
        else if (op == 4'd8 && m_flag) m_pc = m_pc + imm;
        else if (op == 4'd9) m_pc = imm;
        if (mem_op) begin
            v.dreq = 1'b1; v.dwe = (op == 4'd7);
            for (int i = 0; i <= md; i++) push(rbit(), rnd16(), rbit(), (i == md), v);
        end
        if (op <= 4'd4 || op == 4'd6) begin
            v.src = (op <= 4'd4); v.op = (op <= 4'd4) ? op : 4'd0; v.bsel = 1'b0;
            v.dreq = 1'b0; v.dwe = 1'b0;
            v.we = 1'b1; v.wa = rd; v.wsel = (op == 4'd6);
            push(rbit(), rnd16(), rbit(), rbit(), v);
        end
    endtask

    // Replay the schedule: drive on the falling edge, compare 1 ns later
    task automatic run_sched();
        cyc_t c;
        ov_t  a;
        act.delete();
        while (sched.size() > 0) begin
            c = sched.pop_front();
            @(negedge clk);
            instr_valid = c.iv; instr_data = c.id; alu_compare = c.cmp; dmem_ready = c.rdy;
            #1;
            a = dut_vec();
            act.push_back(a);
            check($sformatf("cycle%0d", n_cyc), a, c.exp);
            n_cyc++;
        end
    endtask

    task automatic do_reset();
        ov_t z;
        z = '0;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", dut_vec(), z);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("idle_outputs", dut_vec(), z);
        m_pc = 8'h00;
        m_flag = 1'b0;
    endtask

    initial begin
        int  cnt_req, cnt_we, cnt_dwe, cnt_halt;
        ov_t wb;
        rst_n = 1'b0; instr_valid = 1'b0; instr_data = 16'h0000;
        alu_compare = 1'b0; dmem_ready = 1'b0;
        m_pc = 8'h00; m_flag = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        add_instr(16'h0401, 0, 0, 1'b0);
        run_sched();
        chk_val("add_src_c3", 32'(act[2].src), 32'd1);
        chk_val("add_op_c3", 32'(act[2].op), 32'd0);
        chk_val("add_we_c4", 32'(act[3].we), 32'd1);
        chk_val("add_waddr_c4", 32'(act[3].wa), 32'd1);
        chk_val("add_pc", 32'(act[3].pc), 32'h01);

        for (int f = 1; f >= 0; f--) begin
            do_reset();
            add_instr(16'h5100, 0, 0, 1'(f));
            add_instr(16'h80FC, 0, 0, 1'b0);
            run_sched();
            chk_val($sformatf("beq_pc_dec_flag%0d", f), 32'(act[4].pc), 32'h02);
            @(posedge clk);
            #1;
            chk_val($sformatf("beq_pc_flag%0d", f), 32'(pc), (f == 1) ? 32'hFE : 32'h02);
        end

        add_instr(16'h6905, 0, 3, 1'b0);
        run_sched();
        cnt_req = 0; cnt_we = 0; cnt_dwe = 0; wb = '0;
        foreach (act[i]) begin
            if (act[i].dreq && act[i].bsel) cnt_req++;
            if (act[i].we) begin cnt_we++; wb = act[i]; end
            if (act[i].dwe) cnt_dwe++;
        end
        chk_val("load_req_cycles", 32'(cnt_req), 32'd4);
        chk_val("load_we_cycles", 32'(cnt_we), 32'd1);
        chk_val("load_dwe_cycles", 32'(cnt_dwe), 32'd0);
        chk_val("load_wsel", 32'(wb.wsel), 32'd1);
        chk_val("load_waddr", 32'(wb.wa), 32'd2);

        add_instr(16'h90FF, 0, 0, 1'b0);
        add_instr(16'hA000, 0, 0, 1'b0);
        run_sched();
        chk_val("jmp_fetch_pc", 32'(act[3].pc), 32'hFF);
        chk_val("jmp_wrap_pc", 32'(act[4].pc), 32'h00);

        repeat (60) begin
            add_instr({4'($urandom_range(0, 14)), 12'($urandom)},
                      $urandom_range(0, 2), $urandom_range(0, 3), rbit());
        end
        run_sched();

        do_reset();
        add_instr({4'h7, 12'($urandom)}, 0, 10, 1'b0);
        while (sched.size() > 5) void'(sched.pop_back());
        run_sched();
        chk_val("store_dreq_before_reset", 32'(dmem_req), 32'd1);
        do_reset();
        add_instr(16'h0401, 0, 0, 1'b0);
        run_sched();
        chk_val("post_reset_fetch_pc", 32'(act[0].pc), 32'h00);
        chk_val("post_reset_fetch_req", 32'(act[0].req), 32'd1);

        add_instr(16'hF000, 1, 0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            wb = '0; wb.pc = m_pc; wb.halt = 1'b1;
            push(1'(i % 2), rnd16(), rbit(), rbit(), wb);
        end
        run_sched();
        cnt_halt = 0;
        foreach (act[i]) begin
            if (act[i].halt && !act[i].req) cnt_halt++;
        end
        chk_val("halt_first", 32'(act[3].halt), 32'd1);
        chk_val("halt_hold_cycles", 32'(cnt_halt), 32'd24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_control_unit.md
# alu_control_unit

Multi-cycle instruction sequencer that fetches 16-bit instructions, decodes them and drives the 8-bit ALU, register file and data memory through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It sits between instruction memory and the datapath and is the only block that asserts the ALU's `ALU_src` enable and opcode. It also owns the program counter and the compare flag, and implements branch, jump and halt.

## Interface
- `PC_RESET`, 8'h00: PC value after reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_req` out 1: fetch request; address is `pc`.
- `instr_valid` in 1: `instr_data` valid; accepted only while `instr_req`=1.
- `instr_data` in 16: opcode[15:12], rd[11:10], rs[9:8], imm[7:0].
- `pc` out 8: program counter.
- `alu_opcode` out 4: IR[15:12] to ALU `opcode`.
- `alu_src` out 1: ALU evaluate enable.
- `alu_b_sel` out 1: ALU operand 2 source; 0 = reg rs, 1 = imm.
- `alu_compare` in 1: ALU `compare` output.
- `rf_addr_a` out 2: register read port A, drives ALU operand 1.
- `rf_addr_b` out 2: register read port B.
- `rf_we` out 1: register write strobe.
- `rf_waddr` out 2: register write address.
- `rf_wsel` out 1: write data source; 0 = ALU result, 1 = memory read data.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_ready` in 1: data memory done; completes the request.
- `halted` out 1: halt state reached.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- Reset (async, `rst_n`=0) sets state IDLE, `pc`=`PC_RESET`, IR=0 and flag=0. All outputs are 0 while in reset and in IDLE.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH asserts `instr_req`. When `instr_valid` is sampled 1: IR <= `instr_data`, `pc` <= `pc`+1 (wraps 8'hFF->8'h00), state -> DECODE. The controller waits indefinitely otherwise.
- DECODE always lasts 1 cycle.
  - Read addressing: `rf_addr_a`=IR.rs for LOAD/STORE, otherwise IR.rd; `rf_addr_b`=IR.rs, except STORE uses IR.rd.
  - These addresses are held through EXECUTE, MEM and WB.
  - Opcode 1111 (HALT) -> HALT. All other opcodes -> EXECUTE.
- EXECUTE lasts 1 cycle with `alu_src`=1 and `alu_opcode`=IR.opcode.
  - 0000–0100 (ADD/SUB/AND/OR/XOR): `alu_b_sel`=0, -> WB.
  - 0101 CMP: `alu_b_sel`=0; flag <= `alu_compare` at cycle end; -> FETCH.
  - 0110 LOAD / 0111 STORE: `alu_b_sel`=1 (address = rs+imm); -> MEM.
  - 1000 BEQ: if flag=1, `pc` <= `pc` + imm (8-bit, wraps; `pc` is already incremented); -> FETCH. `alu_src`=0 for this opcode.
  - 1001 JMP: `pc` <= imm; -> FETCH. `alu_src`=0.
  - 1010–1110: NOP, `alu_src`=0; -> FETCH.
- MEM:
  - Outputs: `alu_src`=1, `alu_opcode` and `alu_b_sel` held; `dmem_req`=1; `dmem_we`=1 for STORE.
  - Waits for `dmem_ready`. On ready: LOAD -> WB, STORE -> FETCH.
- WB lasts 1 cycle: `rf_we`=1, `rf_waddr`=IR.rd, `rf_wsel`=1 for LOAD and 0 otherwise; `alu_src`=1 for ALU ops. -> FETCH.
- HALT: `halted`=1 and all strobes 0. It is left only by reset.

## Timing
- State, `pc`, IR and flag are registered. All other outputs are decoded combinationally from state and IR, and are glitch-free relative to `clk` edges.
- Latency with zero-wait memories, counted from the FETCH cycle where `instr_valid` goes high:
  - ALU op: 4 cycles to the next FETCH.
  - CMP/BEQ/JMP/NOP: 3 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
- `instr_valid` while not in FETCH is ignored. `dmem_ready` while not in MEM is ignored.
- Reset asserted mid-instruction (any state, including MEM with `dmem_req` high) drops every output to 0 immediately. No partial register write occurs.
- A flag updated by CMP is visible to a BEQ in the immediately following instruction.

## Test plan
- Reset, then program at 0x00 = 16'h0401 (ADD r1,r0), `instr_valid` same cycle -> `alu_src`=1, `alu_opcode`=0000 in cycle 3; `rf_we`=1, `rf_waddr`=1 in cycle 4; `pc`=0x01.
- CMP (16'h5100) with `alu_compare`=1, then BEQ imm=8'hFC at pc 0x01 -> `pc` goes 0x02 -> 0xFE. Same sequence with `alu_compare`=0 -> `pc`=0x02.
- LOAD 16'h6905 with `dmem_ready` delayed 3 cycles -> `dmem_req`/`alu_b_sel` held 4 cycles; `rf_we`=1, `rf_wsel`=1, `rf_waddr`=2 for exactly 1 cycle; `dmem_we`=0 throughout.
- JMP 16'h90FF, then any instruction at 0xFF -> `pc`=0x00 after fetch (wrap).
- HALT 16'hF000 -> `halted`=1 from the cycle after DECODE; `instr_req` stays 0 for ≥20 cycles despite `instr_valid` toggling.
- `rst_n` pulsed low during MEM of STORE -> `dmem_req`=0 asynchronously; after release `pc`=0x00 and state returns to FETCH via IDLE.
